// File: rtl/gcd_result_queue.sv
// Result-side queue for the GCD core: captures one-cycle result pulses into a FIFO,
// tags each with a sequence number and gates operand issue on guaranteed queue space.
module gcd_result_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 16,
  parameter int unsigned TAGW  = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    io_issue_fire,
  output logic                    io_issue_ok,
  input  logic                    io_res_valid,
  input  logic [WIDTH-1:0]        io_res_data,
  output logic                    io_out_valid,
  input  logic                    io_out_ready,
  output logic [WIDTH-1:0]        io_out_data,
  output logic [TAGW-1:0]         io_out_tag,
  output logic [$clog2(DEPTH):0]  io_count,
  output logic                    io_overflow
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [TAGW-1:0]  tag_q  [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q, count_d;
  logic [TAGW-1:0]  seq_q;
  logic             busy_q, busy_d;
  logic             overflow_q;
  logic             push, pop;

  always_comb begin
    pop  = io_out_valid & io_out_ready;
    // A pop frees the head slot in the same edge, so a full queue can still accept.
    push = io_res_valid & ((count_q < DepthCnt) | pop);

    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CntW'(1);
    end

    // A new issue in the same cycle as a result means a fresh op is in flight.
    busy_d = busy_q;
    if (io_issue_fire) begin
      busy_d = 1'b1;
    end else if (io_res_valid) begin
      busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q     <= '{default: '0};
      tag_q      <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      seq_q      <= '0;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        data_q[wr_ptr_q] <= io_res_data;
        tag_q[wr_ptr_q]  <= seq_q;
        wr_ptr_q         <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      if (io_res_valid) begin
        seq_q <= seq_q + TAGW'(1);
      end
      if (io_res_valid && !push) begin
        overflow_q <= 1'b1;
      end
      count_q <= count_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    io_out_valid = (count_q != '0);
    io_out_data  = data_q[rd_ptr_q];
    io_out_tag   = tag_q[rd_ptr_q];
    io_count     = count_q;
    io_overflow  = overflow_q;
    io_issue_ok  = (count_q + CntW'(busy_q)) < DepthCnt;
  end

endmodule
